// File: rtl/cpu16_bus_pkg.sv
// Shared types and constants for the CPU16 memory/IO bus controller.
package cpu16_bus_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_ROM,
        REG_IO
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_IO_WAIT
    } state_t;

    localparam logic [15:0] DEF_RAM_TOP = 16'h7FFF;
    localparam logic [7:0]  DEF_IO_PAGE = 8'hFE;
    localparam logic [15:0] ERR_DATA    = 16'hFFFF;

endpackage

// File: rtl/cpu16_addr_decode.sv
// Combinational CPU16 address decode: region select and per-region wait-state count.
module cpu16_addr_decode
    import cpu16_bus_pkg::*;
#(
    parameter logic [15:0] RAM_TOP  = DEF_RAM_TOP,
    parameter logic [7:0]  IO_PAGE  = DEF_IO_PAGE,
    parameter int          RAM_WAIT = 0,
    parameter int          ROM_WAIT = 1
) (
    input  logic [15:0] address,
    output region_t     region,
    output logic [3:0]  wait_w
);

    // IO page wins over RAM so the IO window can sit anywhere in the map
    always_comb begin
        region = REG_ROM;
        wait_w = 4'(ROM_WAIT);
        if (address[15:8] == IO_PAGE) begin
            region = REG_IO;
            wait_w = 4'd0;
        end else if (address <= RAM_TOP) begin
            region = REG_RAM;
            wait_w = 4'(RAM_WAIT);
        end
    end

endmodule

// File: rtl/cpu16_bus_ctrl.sv
// CPU16 bus controller: RAM/ROM wait-state insertion and IO req/ack handshake.
// Optional IO ack timeout with sticky bus_err is enabled by defining BUS_TIMEOUT_EN.
module cpu16_bus_ctrl
    import cpu16_bus_pkg::*;
#(
    parameter logic [15:0] RAM_TOP        = DEF_RAM_TOP,
    parameter logic [7:0]  IO_PAGE        = DEF_IO_PAGE,
    parameter int          RAM_WAIT       = 0,
    parameter int          ROM_WAIT       = 1,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write,
    input  logic [15:0] dataOut,
    output logic [15:0] dataIn,
    output logic        hold,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        io_req,
    output logic        io_we,
    output logic [7:0]  io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    input  logic        io_ack,
    output logic        bus_err
);

    // state      | meaning
    // ST_IDLE    | accept a new access; zero-wait memory accesses issue here
    // ST_WAIT    | counting memory wait states; issue when cnt reaches 0
    // ST_IO_WAIT | io_req high, waiting for io_ack (or timeout)

    region_t    region;
    logic [3:0] wait_w;
    state_t     state;
    logic [3:0] cnt;
    logic       rd_pend;
    logic       issue;
    logic       tmo;

    cpu16_addr_decode #(
        .RAM_TOP  (RAM_TOP),
        .IO_PAGE  (IO_PAGE),
        .RAM_WAIT (RAM_WAIT),
        .ROM_WAIT (ROM_WAIT)
    ) u_decode (
        .address (address),
        .region  (region),
        .wait_w  (wait_w)
    );

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tcnt;
    assign tmo = (state == ST_IO_WAIT) && !io_ack && (tcnt == 16'd0);
`else
    assign tmo     = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        hold  = 1'b0;
        issue = 1'b0;
        case (state)
            ST_IDLE: begin
                if (region == REG_IO || wait_w != 4'd0) hold = 1'b1;
                else issue = 1'b1;
            end
            ST_WAIT: begin
                if (cnt != 4'd0) hold = 1'b1;
                else issue = 1'b1;
            end
            ST_IO_WAIT: hold = !(io_ack || tmo);
            default: hold = 1'b0;
        endcase
        // reset must silence the bus at once, including any pending write
        if (reset) begin
            hold  = 1'b0;
            issue = 1'b0;
        end
    end

    assign mem_en    = issue && !(write && region == REG_ROM);
    assign mem_we    = issue && write && (region == REG_RAM);
    assign mem_addr  = address;
    assign mem_wdata = dataOut;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            rd_pend  <= 1'b0;
            dataIn   <= 16'd0;
            io_req   <= 1'b0;
            io_we    <= 1'b0;
            io_addr  <= 8'd0;
            io_wdata <= 16'd0;
`ifdef BUS_TIMEOUT_EN
            tcnt     <= 16'd0;
            bus_err  <= 1'b0;
`endif
        end else begin
            // synchronous memory returns data the cycle after mem_en
            rd_pend <= mem_en && !mem_we;
            if (rd_pend) dataIn <= mem_rdata;
            case (state)
                ST_IDLE: begin
                    if (region == REG_IO) begin
                        io_req   <= 1'b1;
                        io_we    <= write;
                        io_addr  <= address[7:0];
                        io_wdata <= dataOut;
                        state    <= ST_IO_WAIT;
`ifdef BUS_TIMEOUT_EN
                        tcnt     <= TMO_LOAD;
`endif
                    end else if (wait_w != 4'd0) begin
                        cnt   <= wait_w - 4'd1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_IDLE;
                    else cnt <= cnt - 4'd1;
                end
                ST_IO_WAIT: begin
                    if (io_ack) begin
                        io_req <= 1'b0;
                        if (!io_we) dataIn <= io_rdata;
                        state  <= ST_IDLE;
                    end else if (tmo) begin
`ifdef BUS_TIMEOUT_EN
                        io_req  <= 1'b0;
                        if (!io_we) dataIn <= ERR_DATA;
                        bus_err <= 1'b1;
                        state   <= ST_IDLE;
`endif
                    end else begin
`ifdef BUS_TIMEOUT_EN
                        tcnt <= tcnt - 16'd1;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu16_bus_ctrl.md
Name: cpu16_bus_ctrl

Overview:
Memory/IO bus controller sitting directly downstream of CPU16. It consumes the CPU's address, write and dataOut, and produces the CPU's dataIn and hold. It decodes each access into a RAM, ROM or IO region, inserts per-region wait states by asserting hold, and runs a req/ack handshake with IO peripherals.

Parameters:
RAM_TOP, 16'h7FFF, last address of the RAM region (RAM is 0x0000..RAM_TOP).
IO_PAGE, 8'hFE, high byte selecting the IO region (address[15:8]==IO_PAGE).
RAM_WAIT, 0, wait states for RAM accesses (0..15).
ROM_WAIT, 1, wait states for ROM accesses (0..15); ROM is every address not in RAM or IO.
TIMEOUT_CYCLES, 64, IO ack timeout; used only with BUS_TIMEOUT_EN.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
address  in  16  CPU address
write  in  1  CPU write strobe
dataOut  in  16  CPU write data
dataIn  out  16  read data to CPU (registered)
hold  out  1  CPU stall request (combinational)
mem_en  out  1  synchronous memory enable
mem_we  out  1  memory write enable (RAM region only)
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, valid 1 cycle after mem_en
io_req  out  1  IO request, held until io_ack
io_we  out  1  IO write qualifier, valid while io_req
io_addr  out  8  IO register index (address[7:0])
io_wdata  out  16  IO write data
io_rdata  in  16  IO read data, valid with io_ack
io_ack  in  1  IO completion, single-cycle pulse
bus_err  out  1  sticky IO timeout flag (0 when feature absent)

Behaviour:
- Reset (async, any state): state=IDLE; dataIn=0; io_req=0; mem_en=0; mem_we=0; bus_err=0; wait counter=0; latched address/data cleared.
- CPU contract: address, write and dataOut stay stable while hold=1.
- Decode priority: IO page first, then RAM (address<=RAM_TOP), else ROM.
- States: IDLE, WAIT, IO_WAIT.
- IDLE, RAM/ROM access with W==0: mem_en=1 this cycle; mem_we=write&&RAM; hold=0; dataIn<=mem_rdata on the following edge (read latency 1).
- IDLE, RAM/ROM access with W>0: hold=1 this cycle; counter<=W-1; go to WAIT.
- WAIT: hold=(cnt!=0); cnt decrements each cycle. When cnt==0: issue mem_en/mem_we, hold=0, return to IDLE. Read data lands in dataIn one cycle later, same as the W==0 case.
- ROM writes: mem_en=0, mem_we=0, silently dropped; wait states still applied.
- IDLE, IO access: io_req<=1 and latch io_addr/io_we/io_wdata on the next edge; hold=1; go to IO_WAIT.
- IO_WAIT: hold=!io_ack. On io_ack: io_req<=0; on a read, dataIn<=io_rdata; return to IDLE. An io_ack arriving in IDLE is ignored.
- Every cycle accepts one access; there is no "no access" encoding, so reads are issued continuously (e.g. instruction fetch).
- dataIn holds its last value except on a read completion.
- Reset during WAIT or IO_WAIT: abort immediately; io_req drops asynchronously; no memory write is issued.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: in IO_WAIT, a counter counts to TIMEOUT_CYCLES. On expiry: io_req<=0, dataIn<=16'hFFFF (reads), bus_err<=1 (sticky until reset), return to IDLE, hold drops that cycle.
- Undefined: IO_WAIT waits indefinitely; bus_err is tied 0.

Decomposition:
- Package cpu16_bus_pkg: region enum (REG_RAM, REG_ROM, REG_IO), state enum (ST_IDLE, ST_WAIT, ST_IO_WAIT), default RAM_TOP/IO_PAGE constants, 16'hFFFF error-data constant.
- Sub-module cpu16_addr_decode: combinational address -> region plus wait-state count.

Test Plan:
- Reset asserted mid-cycle -> all outputs 0 immediately, state IDLE.
- RAM_WAIT=0: read 0x0010 with mem_rdata=0x1234 -> hold stays 0, mem_en=1 same cycle, dataIn=0x1234 one cycle later.
- ROM_WAIT=1: read 0x9000 -> hold=1 for exactly 1 cycle, mem_en on the second cycle. Write to 0x9000 -> mem_we never asserts.
- IO write to 0xFE05 with data 0xBEEF, io_ack after 3 cycles -> io_addr=0x05, io_we=1, io_wdata=0xBEEF, hold high until the ack cycle, io_req drops next edge.
- IO read, io_rdata=0x00A5 with ack -> dataIn=0x00A5. Reset asserted while io_req=1 -> io_req=0 asynchronously, no dataIn update.
- With BUS_TIMEOUT_EN, IO read with no ack -> after 64 cycles dataIn=0xFFFF, bus_err=1, hold=0. A later acked access leaves bus_err=1.
